// File: rtl/route_in_fifo.sv
// route_in_fifo: 10-bit class+payload FIFO feeding one router input; define ROUTE_IN_FIFO_FWFT_EN for first-word fall-through reads
module route_in_fifo #(
    parameter int WIDTH  = 10,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              pop,
    input  logic [ADDR_W:0]   th_low,
    input  logic [ADDR_W:0]   th_high,
    output logic [WIDTH-1:0]  data_out,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic              error,
    output logic [ADDR_W:0]   occupancy
);
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              error_q, error_d;
    logic              pop_ok, push_ok;

    // Accept/reject decisions and next-state for pointers, count and sticky error
    always_comb begin
        pop_ok   = pop && (count_q != '0);
        push_ok  = push && ((count_q != FULL) || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = (push_ok && !pop_ok) ? count_q + 1'b1 :
                   (pop_ok && !push_ok) ? count_q - 1'b1 : count_q;
        error_d  = error_q || (push && !push_ok) || (pop && !pop_ok);
    end

    // Control state; reset discards every buffered word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            error_q  <= error_d;
        end
    end

    // Storage is never cleared; writes are blocked while reset is held
    always_ff @(posedge clk) begin
        if (push_ok && reset)
            mem_q[wr_ptr_q] <= data_in;
    end

`ifdef ROUTE_IN_FIFO_FWFT_EN
    // Head word is shown as soon as it exists; zero when empty
    always_comb begin
        data_out = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    end
`else
    logic [WIDTH-1:0] dout_q, dout_d;

    // Popped head word is captured and held until the next pop
    always_comb begin
        dout_d = pop_ok ? mem_q[rd_ptr_q] : dout_q;
    end

    // Registered read port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            dout_q <= '0;
        else
            dout_q <= dout_d;
    end

    assign data_out = dout_q;
`endif

    // Flags derive from the registered count and the live thresholds
    always_comb begin
        fifo_empty   = (count_q == '0);
        fifo_full    = (count_q == FULL);
        almost_empty = (count_q <= th_low);
        almost_full  = (count_q >= th_high);
        error        = error_q;
        occupancy    = count_q;
    end
endmodule

// File: tb/tb_route_in_fifo.sv
// tb_route_in_fifo: directed plus random stimulus against a queue-based FIFO model
module tb_route_in_fifo;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       push = 1'b0;
    logic [9:0] data_in = '0;
    logic       pop = 1'b0;
    logic [3:0] th_low = 4'd2;
    logic [3:0] th_high = 4'd6;
    logic [9:0] data_out;
    logic       fifo_empty, fifo_full, almost_empty, almost_full, error;
    logic [3:0] occupancy;

    int checks = 0;
    int errors = 0;

    logic [9:0] q[$];
    logic       err_m = 1'b0;
    logic [9:0] dout_m = '0;

    route_in_fifo dut (
        .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
        .th_low(th_low), .th_high(th_high), .data_out(data_out),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .almost_empty(almost_empty), .almost_full(almost_full),
        .error(error), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [9:0] exp_dout;
`ifdef ROUTE_IN_FIFO_FWFT_EN
        exp_dout = (q.size() != 0) ? q[0] : 10'h000;
`else
        exp_dout = dout_m;
`endif
        chk({tag, ".occupancy"}, 32'(occupancy), 32'(q.size()));
        chk({tag, ".empty"}, 32'(fifo_empty), 32'(q.size() == 0));
        chk({tag, ".full"}, 32'(fifo_full), 32'(q.size() == 8));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(q.size() <= int'(th_low)));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(q.size() >= int'(th_high)));
        chk({tag, ".error"}, 32'(error), 32'(err_m));
        chk({tag, ".data_out"}, 32'(data_out), 32'(exp_dout));
    endtask

    task automatic model_clear();
        q.delete();
        err_m = 1'b0;
        dout_m = '0;
    endtask

    task automatic step(input string tag, input logic pu, input logic [9:0] d, input logic po);
        bit pop_ok, push_ok;
        push = pu;
        data_in = d;
        pop = po;
        @(posedge clk);
        pop_ok = po && q.size() != 0;
        push_ok = pu && (q.size() != 8 || pop_ok);
        if ((pu && !push_ok) || (po && !pop_ok)) err_m = 1'b1;
        if (pop_ok) dout_m = q.pop_front();
        if (push_ok) q.push_back(d);
        @(negedge clk);
        push = 1'b0;
        pop = 1'b0;
        check_all(tag);
    endtask

    initial begin
        push = 1'b1;
        data_in = 10'h1AA;
        repeat (2) begin
            @(negedge clk);
            chk("rst.occupancy", 32'(occupancy), 32'd0);
            chk("rst.empty", 32'(fifo_empty), 32'd1);
            chk("rst.almost_empty", 32'(almost_empty), 32'd1);
            chk("rst.error", 32'(error), 32'd0);
            chk("rst.data_out", 32'(data_out), 32'd0);
        end
        push = 1'b0;
        reset = 1'b1;
        model_clear();
        check_all("post_rst");

        th_low = 4'd2;
        th_high = 4'd6;
        for (int i = 0; i < 8; i++) step("fill", 1'b1, 10'h101 + 10'(i), 1'b0);
        chk("fill.full_literal", 32'(fifo_full), 32'd1);
        step("overflow", 1'b1, 10'h3FF, 1'b0);
        chk("overflow.error_literal", 32'(error), 32'd1);
        for (int i = 0; i < 8; i++) step("drain", 1'b0, 10'h000, 1'b1);

        for (int i = 0; i < 8; i++) step("refill", 1'b1, 10'h200 + 10'(i), 1'b0);
        step("full_pushpop", 1'b1, 10'h2AA, 1'b1);
        for (int i = 0; i < 8; i++) step("wrap_drain", 1'b0, 10'h000, 1'b1);

        for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 10'h0C0 + 10'(i), 1'b0);
        #1 reset = 1'b0;
        model_clear();
        #1 check_all("async_rst");
        #1 reset = 1'b1;
        step("rst_push", 1'b1, 10'h0F0, 1'b0);
        step("rst_pop", 1'b0, 10'h000, 1'b1);

        step("underflow", 1'b1, 10'h055, 1'b1);
        step("underflow_after", 1'b0, 10'h000, 1'b0);

        for (int i = 0; i < 400; i++) begin
            if (i % 37 == 0) begin
                th_low = 4'($urandom_range(0, 9));
                th_high = 4'($urandom_range(0, 9));
            end
            step("random", 1'($urandom_range(0, 99) < 55), 10'($urandom),
                 1'($urandom_range(0, 99) < 50));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
